mem_instr_sequencer: RTL and testbench
======================================

Name: mem_instr_sequencer

Overview:
Parametrised sequencer for the memory-class instructions of the processor, and the successor to the combinational memory decode. It accepts one opcode at a time and fetches its immediate operand from program memory over a req/ack handshake. It then performs the register write, memory store or memory load, and signals completion to the main controller. Register count, data width, opcode bases and handshake timeout are generic.

Parameters:
DATA_W, 8, data/address/immediate width
OPCODE_W, 8, opcode width
NUM_REGS, 4, register-file entries (power of 2, >=2); SEL_W = clog2(NUM_REGS) derived
MVI_BASE, 8'h10, first opcode of MVI group (reg <- immediate); NUM_REGS-aligned
STA_BASE, 8'h20, first opcode of STA group (mem[imm] <- reg); NUM_REGS-aligned
LDA_BASE, 8'h30, first opcode of LDA group (reg <- mem[imm]); NUM_REGS-aligned
TIMEOUT, 16, max wait cycles per handshake; 0 disables timeout

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  opcode presented
instr_ready  out  1  high only in IDLE
opcode  in  OPCODE_W  instruction opcode
op_req  out  1  immediate-operand fetch request
op_ack  in  1  operand valid on op_data
op_data  in  DATA_W  immediate operand
mem_addr  out  DATA_W  data-memory address (captured immediate)
mem_wr_req  out  1  store request
mem_rd_req  out  1  load request
mem_ack  in  1  memory completion; mem_rdata valid on LDA
mem_rdata  in  DATA_W  load data
bank_out_sel  out  SEL_W  register-bank read select (STA source)
dest_reg_wr  out  NUM_REGS  one-hot register write strobe
dest_data  out  DATA_W  register write data
busy  out  1  not IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle error pulse, coincident with done

Behaviour:
- Reset (async, any state): state=IDLE. op_req, mem_wr_req, mem_rd_req, dest_reg_wr, done, err, busy = 0. mem_addr, dest_data, bank_out_sel = 0. Timeout counter = 0. instr_ready=1 once IDLE.
- Decode: opcode in [BASE, BASE+NUM_REGS-1] selects the group; reg index = opcode - BASE.
- Overlapping ranges: priority is MVI > STA > LDA.
- Any other opcode is illegal.
- Opcode, group and index are registered at acceptance (instr_valid && instr_ready).
- States: IDLE, FETCH, WRITE, STORE, LOAD, DONE, ERR.
- IDLE: on acceptance go to FETCH for a legal opcode, ERR for an illegal one. No operand fetch for illegal opcodes.
- FETCH: op_req=1 from the first FETCH cycle until the cycle op_ack is sampled high.
  - op_data is captured into mem_addr (STA/LDA) or dest_data (MVI) on that edge.
  - Next state: MVI -> WRITE, STA -> STORE, LDA -> LOAD.
  - op_req=0 in the following cycle.
- STORE: mem_wr_req=1 and bank_out_sel=index, held until mem_ack. Then -> DONE.
- LOAD: mem_rd_req=1, held until mem_ack. mem_rdata is captured into dest_data on the ack edge. Then -> WRITE.
- WRITE: dest_reg_wr = one-hot(index) for exactly one cycle, with dest_data stable. Then -> DONE.
- DONE: done=1 for one cycle, then -> IDLE.
- ERR: done=1 and err=1 for one cycle, no register write, then -> IDLE.
- Latency, instant acks: MVI 4 cycles acceptance-to-done, STA 4, LDA 5, illegal 2.
- Timeout (TIMEOUT>0):
  - Counter clears on entry to FETCH/STORE/LOAD and increments each wait cycle without ack.
  - If ack is still absent on the TIMEOUT-th cycle, the request drops and the FSM goes to ERR.
  - An ack arriving in the same cycle as expiry wins and is treated as success.
- Acks outside the matching wait state are ignored.
- New opcodes are not accepted while busy; instr_ready=0 outside IDLE.
- bank_out_sel holds its last value outside STORE.
- dest_reg_wr is never multi-hot.
- Reset mid-transaction aborts immediately; all requests drop asynchronously, with no done/err pulse.

Test Plan:
- MVI reg2 (opcode 0x12), op_ack after 3 wait cycles with op_data=0x5A -> op_req high 4 cycles; dest_reg_wr=4'b0100 one cycle with dest_data=0x5A; then done=1, err=0.
- STA reg3 (0x23), op_data=0x80, mem_ack after 2 cycles -> mem_addr=0x80, bank_out_sel=3 while mem_wr_req high 3 cycles, no dest_reg_wr, done pulse.
- LDA reg0 (0x30), op_data=0x44, mem_ack with mem_rdata=0xC3 -> mem_addr=0x44, then dest_reg_wr=4'b0001, dest_data=0xC3, done one cycle later.
- Illegal 0xFF -> no op_req/mem requests; done=err=1 exactly 2 cycles after acceptance; instr_ready returns high.
- TIMEOUT=16, op_ack never asserted -> op_req drops after 16 cycles, err pulse, no write. Repeat with op_ack on cycle 16 -> success path.
- rst_n low during STORE with mem_wr_req=1 -> mem_wr_req=0 immediately, busy=0, no done. A new MVI after release completes normally.

Source files
------------

// File: rtl/mem_instr_sequencer.sv
// Sequencer for memory-class instructions: decodes one opcode, fetches its immediate
// operand over req/ack, then performs a register write, memory store or memory load.
module mem_instr_sequencer #(
  parameter int                    DATA_W   = 8,
  parameter int                    OPCODE_W = 8,
  parameter int                    NUM_REGS = 4,
  parameter logic [OPCODE_W-1:0]   MVI_BASE = 8'h10,
  parameter logic [OPCODE_W-1:0]   STA_BASE = 8'h20,
  parameter logic [OPCODE_W-1:0]   LDA_BASE = 8'h30,
  parameter int                    TIMEOUT  = 16,
  localparam int                   SEL_W    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                op_req,
  input  logic                op_ack,
  input  logic [DATA_W-1:0]   op_data,
  output logic [DATA_W-1:0]   mem_addr,
  output logic                mem_wr_req,
  output logic                mem_rd_req,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [SEL_W-1:0]    bank_out_sel,
  output logic [NUM_REGS-1:0] dest_reg_wr,
  output logic [DATA_W-1:0]   dest_data,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CNT_W = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WRITE, S_STORE, S_LOAD, S_DONE, S_ERR
  } state_t;

  typedef enum logic [1:0] {G_MVI, G_STA, G_LDA, G_ILL} group_t;

  state_t             state_reg, state_next;
  group_t             group_reg, dec_group;
  logic [SEL_W-1:0]   idx_reg;
  logic [DATA_W-1:0]  mem_addr_reg, dest_data_reg;
  logic [SEL_W-1:0]   bank_sel_reg;
  logic [CNT_W-1:0]   tmo_cnt_reg;
  logic               waiting, wait_ack, tmo_hit, accept;

  // Group bases are NUM_REGS-aligned, so range membership reduces to matching the upper bits.
  always_comb begin
    dec_group = G_ILL;
    if (opcode[OPCODE_W-1:SEL_W] == MVI_BASE[OPCODE_W-1:SEL_W])
      dec_group = G_MVI;
    else if (opcode[OPCODE_W-1:SEL_W] == STA_BASE[OPCODE_W-1:SEL_W])
      dec_group = G_STA;
    else if (opcode[OPCODE_W-1:SEL_W] == LDA_BASE[OPCODE_W-1:SEL_W])
      dec_group = G_LDA;
  end

  assign accept  = (state_reg == S_IDLE) && instr_valid;
  assign tmo_hit = (TIMEOUT > 0) && (tmo_cnt_reg == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    waiting    = 1'b0;
    wait_ack   = 1'b0;
    case (state_reg)
      S_IDLE:
        if (instr_valid) state_next = (dec_group == G_ILL) ? S_ERR : S_FETCH;
      S_FETCH: begin
        waiting  = 1'b1;
        wait_ack = op_ack;
        if (op_ack) begin
          case (group_reg)
            G_MVI:   state_next = S_WRITE;
            G_STA:   state_next = S_STORE;
            default: state_next = S_LOAD;
          endcase
        end else if (tmo_hit) begin
          state_next = S_ERR;
        end
      end
      S_STORE: begin
        waiting  = 1'b1;
        wait_ack = mem_ack;
        if (mem_ack)      state_next = S_DONE;
        else if (tmo_hit) state_next = S_ERR;
      end
      S_LOAD: begin
        waiting  = 1'b1;
        wait_ack = mem_ack;
        if (mem_ack)      state_next = S_WRITE;
        else if (tmo_hit) state_next = S_ERR;
      end
      S_WRITE: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Wait counter restarts on every state change so each handshake gets a full budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmo_cnt_reg <= '0;
    else if (state_next != state_reg)
      tmo_cnt_reg <= '0;
    else if (waiting && !wait_ack && (TIMEOUT > 0))
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      group_reg     <= G_ILL;
      idx_reg       <= '0;
      mem_addr_reg  <= '0;
      dest_data_reg <= '0;
      bank_sel_reg  <= '0;
    end else begin
      if (accept) begin
        group_reg <= dec_group;
        idx_reg   <= opcode[SEL_W-1:0];
      end
      if ((state_reg == S_FETCH) && op_ack) begin
        if (group_reg == G_MVI) dest_data_reg <= op_data;
        else                    mem_addr_reg  <= op_data;
        if (group_reg == G_STA) bank_sel_reg  <= idx_reg;
      end
      if ((state_reg == S_LOAD) && mem_ack)
        dest_data_reg <= mem_rdata;
    end
  end

  // Each strobe bit decodes its own index, so at most one can be high.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr
      assign dest_reg_wr[gi] = (state_reg == S_WRITE) && (idx_reg == SEL_W'(gi));
    end
  endgenerate

  assign instr_ready  = (state_reg == S_IDLE);
  assign busy         = (state_reg != S_IDLE);
  assign op_req       = (state_reg == S_FETCH);
  assign mem_wr_req   = (state_reg == S_STORE);
  assign mem_rd_req   = (state_reg == S_LOAD);
  assign done         = (state_reg == S_DONE) || (state_reg == S_ERR);
  assign err          = (state_reg == S_ERR);
  assign mem_addr     = mem_addr_reg;
  assign dest_data    = dest_data_reg;
  assign bank_out_sel = bank_sel_reg;

endmodule

// File: tb/tb_mem_instr_sequencer.sv
// Directed bench for mem_instr_sequencer: MVI/STA/LDA/illegal flows, timeout and async reset.
module tb_mem_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] opcode;
  logic       op_req;
  logic       op_ack;
  logic [7:0] op_data;
  logic [7:0] mem_addr;
  logic       mem_wr_req;
  logic       mem_rd_req;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [1:0] bank_out_sel;
  logic [3:0] dest_reg_wr;
  logic [7:0] dest_data;
  logic       busy;
  logic       done;
  logic       err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_instr_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .opcode       (opcode),
    .op_req       (op_req),
    .op_ack       (op_ack),
    .op_data      (op_data),
    .mem_addr     (mem_addr),
    .mem_wr_req   (mem_wr_req),
    .mem_rd_req   (mem_rd_req),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .bank_out_sel (bank_out_sel),
    .dest_reg_wr  (dest_reg_wr),
    .dest_data    (dest_data),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an opcode for one edge; returns one edge after acceptance.
  task automatic issue(input logic [7:0] op);
    instr_valid = 1'b1;
    opcode      = op;
    step();
    instr_valid = 1'b0;
    $display("issue opcode=%02h", op);
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; opcode = '0;
    op_ack = 1'b0; op_data = '0; mem_ack = 1'b0; mem_rdata = '0;
    step(); step();
    check("rst_instr_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_op_req", op_req, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_wr", dest_reg_wr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_bank_sel", bank_out_sel, 0);
    rst_n = 1'b1;
    step();

    // MVI reg2, ack on the 4th FETCH cycle; a stray opcode while busy must be ignored.
    issue(8'h12);
    check("mvi_op_req_c1", op_req, 1);
    check("mvi_ready_low", instr_ready, 0);
    instr_valid = 1'b1; opcode = 8'h30;
    step();
    instr_valid = 1'b0;
    check("mvi_op_req_c2", op_req, 1);
    step();
    check("mvi_op_req_c3", op_req, 1);
    step();
    op_ack = 1'b1; op_data = 8'h5A;
    check("mvi_op_req_c4", op_req, 1);
    step();
    op_ack = 1'b0;
    check("mvi_op_req_drop", op_req, 0);
    check("mvi_wr", dest_reg_wr, 4'b0100);
    check("mvi_data", dest_data, 8'h5A);
    check("mvi_done_early", done, 0);
    step();
    check("mvi_done_err", {done, err}, 2'b10);
    check("mvi_wr_once", dest_reg_wr, 0);
    step();
    check("mvi_idle", {instr_ready, busy, done}, 3'b100);

    // STA reg3, instant operand, mem_ack on the 3rd STORE cycle.
    issue(8'h23);
    op_ack = 1'b1; op_data = 8'h80;
    step();
    op_ack = 1'b0;
    check("sta_wr_req_c1", mem_wr_req, 1);
    check("sta_addr", mem_addr, 8'h80);
    check("sta_bank", bank_out_sel, 3);
    check("sta_no_wr", dest_reg_wr, 0);
    step();
    check("sta_wr_req_c2", mem_wr_req, 1);
    step();
    mem_ack = 1'b1;
    check("sta_wr_req_c3", mem_wr_req, 1);
    step();
    mem_ack = 1'b0;
    check("sta_wr_req_drop", mem_wr_req, 0);
    check("sta_done_err", {done, err}, 2'b10);
    check("sta_no_wr_done", dest_reg_wr, 0);
    step();
    check("sta_bank_hold", bank_out_sel, 3);

    // LDA reg0 with a stray mem_ack during FETCH that must be ignored.
    issue(8'h30);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("lda_stray_ack", {op_req, mem_rd_req}, 2'b10);
    op_ack = 1'b1; op_data = 8'h44;
    step();
    op_ack = 1'b0;
    check("lda_rd_req", mem_rd_req, 1);
    check("lda_addr", mem_addr, 8'h44);
    mem_ack = 1'b1; mem_rdata = 8'hC3;
    step();
    mem_ack = 1'b0;
    check("lda_rd_drop", mem_rd_req, 0);
    check("lda_wr", dest_reg_wr, 4'b0001);
    check("lda_data", dest_data, 8'hC3);
    check("lda_done_early", done, 0);
    step();
    check("lda_done_err", {done, err}, 2'b10);
    step();

    // Illegal opcode goes straight to the error pulse.
    issue(8'hFF);
    check("ill_reqs", {op_req, mem_wr_req, mem_rd_req}, 0);
    check("ill_done_err", {done, err}, 2'b11);
    check("ill_no_wr", dest_reg_wr, 0);
    step();
    check("ill_pulse_end", {done, err}, 0);
    check("ill_ready", instr_ready, 1);

    // Operand never acknowledged: request held 16 cycles, then error.
    issue(8'h11);
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("tmo_op_req_c%0d", i), op_req, 1);
      step();
    end
    check("tmo_op_req_drop", op_req, 0);
    check("tmo_done_err", {done, err}, 2'b11);
    check("tmo_no_wr", dest_reg_wr, 0);
    step();

    // Ack on the 16th cycle wins over expiry.
    issue(8'h13);
    for (int i = 1; i <= 15; i++) step();
    op_ack = 1'b1; op_data = 8'h77;
    check("tmo16_op_req", op_req, 1);
    step();
    op_ack = 1'b0;
    check("tmo16_no_err", {done, err}, 0);
    check("tmo16_wr", dest_reg_wr, 4'b1000);
    check("tmo16_data", dest_data, 8'h77);
    step();
    check("tmo16_done_err", {done, err}, 2'b10);
    step();

    // Asynchronous reset in the middle of a store.
    issue(8'h20);
    op_ack = 1'b1; op_data = 8'h10;
    step();
    op_ack = 1'b0;
    check("rst_mid_store_req", mem_wr_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_wr_req", mem_wr_req, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", {done, err}, 0);
    step();
    check("rst_mid_held", {done, err, busy}, 0);
    rst_n = 1'b1;
    step();
    issue(8'h10);
    op_ack = 1'b1; op_data = 8'h3C;
    step();
    op_ack = 1'b0;
    check("post_rst_wr", dest_reg_wr, 4'b0001);
    check("post_rst_data", dest_data, 8'h3C);
    step();
    check("post_rst_done_err", {done, err}, 2'b10);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
